// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and defaults for the synch_fifo read side.
package sync_fifo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} reader_state_e;
  localparam int DEF_FIFO_PTR = 4;
  localparam int DEF_FIFO_WIDTH = 32;
  localparam int RD_BUF_DEPTH = 2;
endpackage

// File: rtl/fifo_rd_buf2.sv
// fifo_rd_buf2: 2-entry in-order buffer absorbing the FIFO read latency.
module fifo_rd_buf2 import sync_fifo_pkg::*; #(
  parameter int WIDTH = DEF_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);
  logic [WIDTH-1:0] mem [RD_BUF_DEPTH];
  logic rd_ptr, wr_ptr;
  assign head_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= push_data;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: synch_fifo read controller with valid/ready output and drain.
// Optional SYNC_FIFO_READER_CNT_EN adds the rd_count delivered-word counter.
module sync_fifo_reader import sync_fifo_pkg::*; #(
  parameter int FIFO_PTR = DEF_FIFO_PTR,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  drain_req,
  input  logic                  empty,
  input  logic [FIFO_PTR:0]     data_avail,
  input  logic [FIFO_WIDTH-1:0] read_data,
  output logic                  read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
`ifdef SYNC_FIFO_READER_CNT_EN
  output logic [31:0]           rd_count,
`endif
  output logic                  busy,
  output logic                  drain_done
);
  reader_state_e state;
  logic [1:0] occ;
  logic inflight, pop, done_fire;
  logic [2:0] level;
  fifo_rd_buf2 #(.WIDTH(FIFO_WIDTH)) u_buf (
    .clk(clk), .rst(rst), .push(inflight), .push_data(read_data),
    .pop(pop), .head_data(m_data), .occ(occ)
  );
  assign m_valid = occ != 2'd0;
  assign pop = m_valid && m_ready;
  // words held or owed after this cycle, before any new read
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign read_en = !rst && !empty && (run || state == DRAIN) && level < 3'd2;
  assign busy = state == DRAIN;
  // completion is judged on post-cycle occupancy so the pulse follows the last accept directly
  assign done_fire = empty && data_avail == '0 && level == 3'd0 && (busy || drain_req);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inflight <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      inflight <= read_en;
      drain_done <= done_fire;
      state <= (done_fire || (!busy && !drain_req)) ? (run ? RUN : IDLE) : DRAIN;
    end
  end
`ifdef SYNC_FIFO_READER_CNT_EN
  always_ff @(posedge clk) rd_count <= (rst || done_fire) ? 32'd0 : rd_count + {31'd0, pop};
`endif
endmodule
